scale_tonegen: RTL and testbench
================================

# scale_tonegen

Parametrised square-wave tone generator that steps through a C-major scale across several octaves in response to encoder step pulses. It replaces the fixed encoder-to-frequency plus tone-generator pair in the board top level. Its outputs are:
- `spkr`, driving the buzzer.
- `note` and `octave`, the current scale position.
- `freq_hz`, the current pitch, for the 7-segment display path.

Compared with the previous generation it adds octave carry, selectable wrap/saturate behaviour, glitch-free pitch changes and a clean mute.

## Interface
- `FCLK`, 50000000, clock frequency in Hz; sets the half-period table.
- `OCT_BITS`, 2, octave register width; octaves 0..2^OCT_BITS-1.
- `WRAP`, 1, step mode at scale ends: 1 carries into the next/previous octave, 0 saturates.
- `FW`, 16, width of `freq_hz`.
- `clk` input 1: system clock.
- `reset` input 1: reset, asynchronous, active-high.
- `cw` input 1: one-cycle step-up pulse from the encoder.
- `ccw` input 1: one-cycle step-down pulse from the encoder.
- `en` input 1: 1 means play tone, 0 means mute.
- `spkr` output 1: square-wave buzzer drive.
- `note` output 3: scale index 0..7 (C4 D E F G A B C5).
- `octave` output OCT_BITS: octave shift.
- `freq_hz` output FW: base frequency << octave, saturated to 2^FW-1.
- `active` output 1: high whenever the state is not IDLE.

## Operation
- **Base table.**
  - Frequencies: 262, 294, 330, 349, 392, 440, 494, 523 Hz.
  - Half-period constants are computed at elaboration: HALF[i] = floor(FCLK / (2·base[i])).
  - Values for FCLK=50 MHz: 95419, 85034, 75757, 71633, 63775, 56818, 50607, 47801.
- **Effective half-period.** HALF[note] >> octave, with a minimum of 1.
- **Step logic.**
  - `cw` and `ccw` both high in the same cycle: ignored.
  - `cw` with note<7: note+1.
  - `cw` with note=7:
    - WRAP=1 and octave<max: note=1, octave+1. C5 equals C of the next octave, so index 0 is skipped.
    - Otherwise: no change.
  - `ccw` with note>0: note-1.
  - `ccw` with note=0:
    - WRAP=1 and octave>0: note=6, octave-1.
    - Otherwise: no change.
- **Output state machine.** States are IDLE, HIGH and LOW; `spkr` = (state==HIGH).
  - IDLE: counter=0. If `en`=1, load the latched half-period and go to HIGH.
  - HIGH: decrement the counter. At 0, reload the latched half-period and go to LOW. If `en`=0 at that point, go to IDLE instead.
  - LOW: decrement the counter. At 0, reload and go to HIGH if `en`=1, otherwise go to IDLE.
  - LOW with `en`=0 before the count ends: go to IDLE on the next cycle.
- **Glitch-free pitch change.**
  - The half-period is latched only at load/reload.
  - A note or octave change mid-half-period takes effect at the next toggle; no truncated or extended half-periods.
- **Mute.** A high pulse is never truncated. `en` falling during HIGH completes that half-period.
- **`freq_hz`.** Combinational from the registered `note`/`octave`: base[note] << octave, clamped to 2^FW-1.

## Timing
- **Reset values:** `note`=0, `octave`=0, state=IDLE, `spkr`=0, `active`=0, counter=0, latched half=HALF[0]. `freq_hz`=262.
- **Asynchronous reset mid-tone:** immediately returns all state to the reset values.
- **Step latency:** a step pulse in cycle n updates `note`, `octave` and `freq_hz` at edge n+1.
- **Enable latency:** `en` sampled high in IDLE at edge n gives `spkr`=1 from edge n+1.
- **Half-period length:** each HIGH and LOW phase lasts exactly H+1 cycles, where H = latched half-period minus 1 as loaded; the load value is half-1. The tone period is therefore exactly 2·half cycles.
- **Mute from IDLE:** `en` low in IDLE keeps `spkr`=0 with no activity.
- **Counter width:** must hold HALF[0] for the given FCLK (17 bits at 50 MHz). The implementation derives it with $clog2.

## Test plan
Bench FCLK=100000: HALF = 190, 170, 151, 143, 127, 113, 101, 95.

1. **Reset/idle.** Assert `reset` mid-tone, release, hold `en`=0 for 1000 cycles -> `spkr`=0, `active`=0, `note`=0, `octave`=0, `freq_hz`=262.
2. **Tone period.** `en`=1 at note 0 -> `spkr` high exactly 190 cycles, then low 190, repeating. Five `cw` pulses (note 5, A) -> `freq_hz`=440 and half-period 113 cycles from the next toggle.
3. **Octave carry, WRAP=1.**
   - Eight `cw` from reset -> `note`=1, `octave`=1, `freq_hz`=588, half-period 85.
   - One `ccw` -> `note`=0, `octave`=1, `freq_hz`=524.
   - Another `ccw` -> `note`=6, `octave`=0, `freq_hz`=494.
4. **Saturation.**
   - WRAP=0: 20 `cw` -> `note`=7, `octave`=0.
   - WRAP=1: 40 `cw` -> `note`=7, `octave`=3, `freq_hz`=4184.
   - WRAP=0: `ccw` at note 0 -> no change.
5. **Simultaneous and mid-period events.**
   - `cw`&`ccw` in the same cycle -> no change.
   - `cw` 50 cycles into a HIGH phase -> the current HIGH still lasts the old half; the next phase uses the new half.
6. **Clean mute.** `en` falls 10 cycles into HIGH -> `spkr` stays high until the full half-period completes, then goes to IDLE with `spkr`=0 and `active`=0. `en` falls during LOW -> IDLE on the next cycle.

Source files
------------

// File: rtl/scale_tonegen.sv
// C-major scale tone generator: encoder steps move note/octave, FSM drives a square wave
// whose half-period is latched only at phase boundaries so pitch changes never glitch.
module scale_tonegen #(
    parameter int unsigned FCLK     = 50000000,
    parameter int unsigned OCT_BITS = 2,
    parameter bit          WRAP     = 1'b1,
    parameter int unsigned FW       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cw,
    input  logic                ccw,
    input  logic                en,
    output logic                spkr,
    output logic [2:0]          note,
    output logic [OCT_BITS-1:0] octave,
    output logic [FW-1:0]       freq_hz,
    output logic                active
);

    localparam int unsigned CNT_W = $clog2(FCLK / 524 + 1);
    localparam int unsigned SW    = 9 + (1 << OCT_BITS);
    localparam int unsigned XW    = (SW > FW) ? SW : FW;

    localparam logic [9:0] BASE [8] = '{
        10'd262, 10'd294, 10'd330, 10'd349, 10'd392, 10'd440, 10'd494, 10'd523
    };

    localparam logic [CNT_W-1:0] HALF [8] = '{
        CNT_W'(FCLK / (2 * 262)), CNT_W'(FCLK / (2 * 294)),
        CNT_W'(FCLK / (2 * 330)), CNT_W'(FCLK / (2 * 349)),
        CNT_W'(FCLK / (2 * 392)), CNT_W'(FCLK / (2 * 440)),
        CNT_W'(FCLK / (2 * 494)), CNT_W'(FCLK / (2 * 523))
    };

    localparam logic [OCT_BITS-1:0] OCT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          note_q, note_d;
    logic [OCT_BITS-1:0] oct_q, oct_d;
    logic [CNT_W-1:0]    eff_half;
    logic [CNT_W-1:0]    load_val;
    logic [XW-1:0]       wide_f;

    always_comb begin
        note_d = note_q;
        oct_d  = oct_q;
        if (cw && !ccw) begin
            if (note_q != 3'd7) begin
                note_d = note_q + 3'd1;
            end else if (WRAP && (oct_q != OCT_MAX)) begin
                // C5 is C of the next octave, so the carry lands on D.
                note_d = 3'd1;
                oct_d  = oct_q + OCT_BITS'(1);
            end
        end else if (ccw && !cw) begin
            if (note_q != 3'd0) begin
                note_d = note_q - 3'd1;
            end else if (WRAP && (oct_q != '0)) begin
                note_d = 3'd6;
                oct_d  = oct_q - OCT_BITS'(1);
            end
        end
    end

    always_comb begin
        eff_half = HALF[note_q] >> oct_q;
        if (eff_half == '0) begin
            eff_half = CNT_W'(1);
        end
        load_val = eff_half - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    cnt_d   = load_val;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // A high pulse always runs to completion; mute is honoured only at its end.
                if (cnt_q == '0) begin
                    if (en) begin
                        cnt_d   = load_val;
                        state_d = LOW;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (!en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = load_val;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
        end
    end

    always_comb begin
        wide_f = XW'(BASE[note_q]) << oct_q;
        if (wide_f > XW'({FW{1'b1}})) begin
            freq_hz = '1;
        end else begin
            freq_hz = wide_f[FW-1:0];
        end
    end

    assign spkr   = (state_q == HIGH);
    assign active = (state_q != IDLE);
    assign note   = note_q;
    assign octave = oct_q;

endmodule

// File: tb/tb_scale_tonegen.sv
// Directed bench for scale_tonegen at FCLK=100 kHz (HALF = 190,170,151,143,127,113,101,95),
// with wrapping, saturating and narrow-freq_hz instances sharing one stimulus.
module tb_scale_tonegen;

    logic        clk;
    logic        reset;
    logic        cw;
    logic        ccw;
    logic        en;

    logic        spkr_w, active_w;
    logic [2:0]  note_w;
    logic [1:0]  oct_w;
    logic [15:0] freq_w;

    logic        spkr_s, active_s;
    logic [2:0]  note_s;
    logic [1:0]  oct_s;
    logic [15:0] freq_s;

    logic        spkr_c, active_c;
    logic [2:0]  note_c;
    logic [1:0]  oct_c;
    logic [11:0] freq_c;

    int errors;
    int checks;

    scale_tonegen #(.FCLK(100000), .OCT_BITS(2), .WRAP(1'b1), .FW(16)) dut_w (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .en(en),
        .spkr(spkr_w), .note(note_w), .octave(oct_w), .freq_hz(freq_w), .active(active_w)
    );

    scale_tonegen #(.FCLK(100000), .OCT_BITS(2), .WRAP(1'b0), .FW(16)) dut_s (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .en(en),
        .spkr(spkr_s), .note(note_s), .octave(oct_s), .freq_hz(freq_s), .active(active_s)
    );

    scale_tonegen #(.FCLK(100000), .OCT_BITS(2), .WRAP(1'b1), .FW(12)) dut_c (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .en(en),
        .spkr(spkr_c), .note(note_c), .octave(oct_c), .freq_hz(freq_c), .active(active_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive cycles with spkr at the given level, bounded at 1000.
    task automatic measure(input logic level, output int len);
        len = 0;
        while (spkr_w === level && len < 1000) begin
            len++;
            tick();
        end
    endtask

    task automatic do_reset();
        en    = 1'b0;
        cw    = 1'b0;
        ccw   = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        cw = 1'b1;
        repeat (2) tick();
        cw = 1'b0;
        en = 1'b1;
        repeat (300) tick();
        checks++;
        if (active_w !== 1'b1) begin
            errors++; $display("FAIL reset_pre_active: got %0b expected 1", active_w);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (active_w !== 1'b0 || spkr_w !== 1'b0 || note_w !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: got active=%0b spkr=%0b note=%0d expected 0 0 0",
                     active_w, spkr_w, note_w);
        end
        en = 1'b0;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (spkr_w !== 1'b0 || active_w !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL reset_idle_quiet: got %0d active cycles expected 0", bad);
        end
        checks++;
        if (note_w !== 3'd0 || oct_w !== 2'd0) begin
            errors++; $display("FAIL reset_pos: got note=%0d oct=%0d expected 0 0", note_w, oct_w);
        end
        checks++;
        if (freq_w !== 16'd262) begin
            errors++; $display("FAIL reset_freq: got %0d expected 262", freq_w);
        end
    endtask

    task automatic test_tone();
        int len;
        do_reset();
        en = 1'b1;
        tick();
        checks++;
        if (spkr_w !== 1'b1) begin
            errors++; $display("FAIL en_latency: got %0b expected 1", spkr_w);
        end
        measure(1'b1, len);
        checks++;
        if (len !== 190) begin errors++; $display("FAIL tone_high0: got %0d expected 190", len); end
        measure(1'b0, len);
        checks++;
        if (len !== 190) begin errors++; $display("FAIL tone_low0: got %0d expected 190", len); end
        measure(1'b1, len);
        checks++;
        if (len !== 190) begin errors++; $display("FAIL tone_high1: got %0d expected 190", len); end
        measure(1'b0, len);
        // now in cycle 1 of a HIGH phase
        cw = 1'b1;
        repeat (5) tick();
        cw = 1'b0;
        checks++;
        if (note_w !== 3'd5 || freq_w !== 16'd440) begin
            errors++; $display("FAIL tone_a_note: got note=%0d freq=%0d expected 5 440", note_w, freq_w);
        end
        measure(1'b1, len);
        checks++;
        if (len !== 185) begin errors++; $display("FAIL tone_old_high: got %0d expected 185", len); end
        measure(1'b0, len);
        checks++;
        if (len !== 113) begin errors++; $display("FAIL tone_a_low: got %0d expected 113", len); end
        measure(1'b1, len);
        checks++;
        if (len !== 113) begin errors++; $display("FAIL tone_a_high: got %0d expected 113", len); end
    endtask

    task automatic test_carry();
        int len;
        do_reset();
        cw = 1'b1;
        repeat (8) tick();
        cw = 1'b0;
        checks++;
        if (note_w !== 3'd1 || oct_w !== 2'd1 || freq_w !== 16'd588) begin
            errors++;
            $display("FAIL carry_up: got note=%0d oct=%0d freq=%0d expected 1 1 588", note_w, oct_w, freq_w);
        end
        en = 1'b1;
        tick();
        measure(1'b1, len);
        checks++;
        if (len !== 85) begin errors++; $display("FAIL carry_half: got %0d expected 85", len); end
        en = 1'b0;
        tick();
        checks++;
        if (active_w !== 1'b0 || spkr_w !== 1'b0) begin
            errors++; $display("FAIL mute_low: got active=%0b spkr=%0b expected 0 0", active_w, spkr_w);
        end
        ccw = 1'b1;
        tick();
        ccw = 1'b0;
        checks++;
        if (note_w !== 3'd0 || oct_w !== 2'd1 || freq_w !== 16'd524) begin
            errors++;
            $display("FAIL carry_dn1: got note=%0d oct=%0d freq=%0d expected 0 1 524", note_w, oct_w, freq_w);
        end
        ccw = 1'b1;
        tick();
        ccw = 1'b0;
        checks++;
        if (note_w !== 3'd6 || oct_w !== 2'd0 || freq_w !== 16'd494) begin
            errors++;
            $display("FAIL carry_dn2: got note=%0d oct=%0d freq=%0d expected 6 0 494", note_w, oct_w, freq_w);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        cw = 1'b1;
        repeat (20) tick();
        checks++;
        if (note_s !== 3'd7 || oct_s !== 2'd0) begin
            errors++; $display("FAIL sat_nowrap_top: got note=%0d oct=%0d expected 7 0", note_s, oct_s);
        end
        repeat (20) tick();
        cw = 1'b0;
        checks++;
        if (note_w !== 3'd7 || oct_w !== 2'd3 || freq_w !== 16'd4184) begin
            errors++;
            $display("FAIL sat_wrap_top: got note=%0d oct=%0d freq=%0d expected 7 3 4184", note_w, oct_w, freq_w);
        end
        checks++;
        if (freq_c !== 12'd4095) begin
            errors++; $display("FAIL freq_clamp: got %0d expected 4095", freq_c);
        end
        do_reset();
        ccw = 1'b1;
        tick();
        ccw = 1'b0;
        checks++;
        if (note_s !== 3'd0 || oct_s !== 2'd0 || note_w !== 3'd0 || oct_w !== 2'd0) begin
            errors++;
            $display("FAIL sat_bottom: got s=%0d/%0d w=%0d/%0d expected 0/0 0/0", note_s, oct_s, note_w, oct_w);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cw  = 1'b1;
        ccw = 1'b1;
        tick();
        checks++;
        if (note_w !== 3'd0 || oct_w !== 2'd0) begin
            errors++; $display("FAIL both_at0: got note=%0d oct=%0d expected 0 0", note_w, oct_w);
        end
        ccw = 1'b0;
        repeat (2) tick();
        ccw = 1'b1;
        tick();
        cw  = 1'b0;
        ccw = 1'b0;
        checks++;
        if (note_w !== 3'd2) begin
            errors++; $display("FAIL both_at2: got note=%0d expected 2", note_w);
        end
    endtask

    task automatic test_mid_change();
        int len;
        do_reset();
        en = 1'b1;
        tick();
        repeat (49) tick();
        cw = 1'b1;
        tick();
        cw = 1'b0;
        measure(1'b1, len);
        checks++;
        if (len !== 140) begin errors++; $display("FAIL mid_high_rest: got %0d expected 140", len); end
        measure(1'b0, len);
        checks++;
        if (len !== 170) begin errors++; $display("FAIL mid_next_low: got %0d expected 170", len); end
    endtask

    task automatic test_mute();
        int len;
        do_reset();
        en = 1'b1;
        tick();
        repeat (10) tick();
        en = 1'b0;
        measure(1'b1, len);
        checks++;
        if (len !== 180) begin errors++; $display("FAIL mute_high_rest: got %0d expected 180", len); end
        checks++;
        if (spkr_w !== 1'b0 || active_w !== 1'b0) begin
            errors++; $display("FAIL mute_idle: got spkr=%0b active=%0b expected 0 0", spkr_w, active_w);
        end
        en = 1'b1;
        tick();
        measure(1'b1, len);
        repeat (20) tick();
        checks++;
        if (active_w !== 1'b1 || spkr_w !== 1'b0) begin
            errors++; $display("FAIL mute_in_low: got active=%0b spkr=%0b expected 1 0", active_w, spkr_w);
        end
        en = 1'b0;
        tick();
        checks++;
        if (active_w !== 1'b0) begin
            errors++; $display("FAIL mute_low_exit: got %0b expected 0", active_w);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        en     = 1'b0;
        cw     = 1'b0;
        ccw    = 1'b0;
        test_reset();
        test_tone();
        test_carry();
        test_saturate();
        test_simultaneous();
        test_mid_change();
        test_mute();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
